alien_wave_controller: RTL and testbench

ALIEN_WAVE_CONTROLLER -- requirements
Module: alien_wave_controller

---
 rtl/alien_wave_controller.sv | 158 +++++++++++++++
 tb/tb_alien_wave_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_wave_controller.sv
// Alien wave sequencer: spawns aliens, tracks flight, scores dodges and lives.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   start          : begin/restart a game (IDLE/OVER only)
//   traj_ready     : alien on-screen with a valid position
//   traj_collision : alien hit the spaceship
//   spawn          : one-clock registered pulse restarting the trajectory
//   angle_state    : approach direction of the current alien
//   lives, score   : remaining lives and aliens dodged
//   game_over      : lives exhausted
//   busy           : game in progress (not IDLE/OVER)
module alien_wave_controller #(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned SPAWN_GAP   = 8,
  parameter int unsigned FLY_TIMEOUT = 200,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       traj_ready,
  input  logic       traj_collision,
  output logic       spawn,
  output logic [3:0] angle_state,
  output logic [2:0] lives,
  output logic [7:0] score,
  output logic       game_over,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    ARM,
    FLY,
    HIT,
    GAP,
    OVER
  } state_t;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [9:0] FLY_LAST   = 10'(FLY_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST   = 8'(SPAWN_GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] angle_q, angle_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic       spawn_q, spawn_d;
  logic [9:0] fly_cnt_q, fly_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;

  logic       timeout;
  logic [7:0] score_inc;

  assign timeout   = (fly_cnt_q == FLY_LAST);
  assign score_inc = (score_q == 8'hFF) ? score_q
                                        : score_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5] ^
                 lfsr_q[4] ^ lfsr_q[3]};
    angle_d   = angle_q;
    lives_d   = lives_q;
    score_d   = score_q;
    spawn_d   = 1'b0;
    fly_cnt_d = fly_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          lives_d = LIVES_INIT;
          score_d = 8'd0;
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        spawn_d   = 1'b1;
        angle_d   = lfsr_q[3:0];
        fly_cnt_d = 10'd0;
        state_d   = ARM;
      end
      ARM: begin
        // ready is low while the generator initialises,
        // so only collision or timeout leave ARM early
        fly_cnt_d = fly_cnt_q + 10'd1;
        if (traj_collision) begin
          state_d = HIT;
        end else if (timeout) begin
          gap_cnt_d = 8'd0;
          state_d   = GAP;
        end else if (traj_ready) begin
          state_d = FLY;
        end
      end
      FLY: begin
        fly_cnt_d = fly_cnt_q + 10'd1;
        if (traj_collision) begin
          state_d = HIT;
        end else if (!traj_ready || timeout) begin
          score_d   = score_inc;
          gap_cnt_d = 8'd0;
          state_d   = GAP;
        end
      end
      HIT: begin
        lives_d   = (lives_q == 3'd0) ? 3'd0
                                      : lives_q - 3'd1;
        gap_cnt_d = 8'd0;
        state_d   = (lives_q <= 3'd1) ? OVER : GAP;
      end
      GAP: begin
        // collision may still be held here; ignored
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = SPAWN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      angle_q   <= 4'd0;
      lives_q   <= 3'd0;
      score_q   <= 8'd0;
      spawn_q   <= 1'b0;
      fly_cnt_q <= 10'd0;
      gap_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      angle_q   <= angle_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      spawn_q   <= spawn_d;
      fly_cnt_q <= fly_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign spawn       = spawn_q;
  assign angle_state = angle_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign game_over   = (state_q == OVER);
  assign busy        = (state_q != IDLE) &&
                       (state_q != OVER);

endmodule

// File: tb/tb_alien_wave_controller.sv
// Directed bench for alien_wave_controller.
// Expected values are queued on stimulus and popped at each check.
module tb_alien_wave_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       traj_ready;
  logic       traj_collision;
  logic       spawn;
  logic [3:0] angle_state;
  logic [2:0] lives;
  logic [7:0] score;
  logic       game_over;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  logic [7:0] m_lfsr;
  logic [7:0] m_prev;

  alien_wave_controller #(
    .LIVES(3),
    .SPAWN_GAP(8),
    .FLY_TIMEOUT(200),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .traj_ready(traj_ready),
    .traj_collision(traj_collision),
    .spawn(spawn),
    .angle_state(angle_state),
    .lives(lives),
    .score(score),
    .game_over(game_over),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr = 8'hA5;
      m_prev = 8'hA5;
    end else begin
      m_prev = m_lfsr;
      m_lfsr = {m_lfsr[6:0],
                m_lfsr[7] ^ m_lfsr[5] ^
                m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, got %0d",
             tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_spawn(output int n);
    n = 0;
    while (spawn !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    push(1);
    chk("spawn_seen", {31'd0, spawn});
  endtask

  task automatic chk_angle();
    push({28'd0, m_prev[3:0]});
    chk("angle", {28'd0, angle_state});
  endtask

  task automatic escape_one();
    int n;
    traj_ready = 1'b1;
    tick();
    traj_ready = 1'b0;
    tick();
    wait_spawn(n);
  endtask

  initial begin
    int n;
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    traj_ready = 1'b0;
    traj_collision = 1'b0;
    #3;
    push(0); chk("rst_lives", lives);
    push(0); chk("rst_score", score);
    push(0); chk("rst_busy", busy);
    push(0); chk("rst_spawn", spawn);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    push(0); chk("idle_busy", busy);

    // start: lives loaded, then one spawn pulse
    start = 1'b1;
    push(3); push(0); push(1); push(0);
    tick();
    start = 1'b0;
    chk("start_lives", lives);
    chk("start_score", score);
    chk("start_busy", busy);
    chk("start_spawn", spawn);
    tick();
    push(1); chk("spawn_pulse", spawn);
    chk_angle();

    // ready low 2, high 10, then low -> escape
    tick();
    push(0); chk("spawn_one_clk", spawn);
    tick();
    traj_ready = 1'b1;
    repeat (10) tick();
    traj_ready = 1'b0;
    push(1);
    tick();
    chk("escape_score", score);
    wait_spawn(n);
    push(9); chk("gap_len", n);
    chk_angle();

    // collision and ready low in one FLY clock
    traj_ready = 1'b1;
    tick();
    traj_ready = 1'b0;
    traj_collision = 1'b1;
    tick();
    tick();
    push(2); chk("hit_lives", lives);
    push(1); chk("hit_score", score);
    start = 1'b1;
    tick();
    start = 1'b0;
    push(2); chk("start_ignored", lives);
    wait_spawn(n);
    traj_collision = 1'b0;
    push(2); chk("gap_no_dec", lives);

    // two more collisions -> game over
    traj_collision = 1'b1;
    tick();
    traj_collision = 1'b0;
    tick();
    push(1); chk("lives_1", lives);
    wait_spawn(n);
    traj_collision = 1'b1;
    tick();
    traj_collision = 1'b0;
    tick();
    push(0); chk("over_lives", lives);
    push(1); chk("over_flag", game_over);
    push(0); chk("over_busy", busy);
    push(1); chk("over_score", score);
    k = 0;
    repeat (30) begin
      tick();
      if (spawn === 1'b1) k++;
    end
    push(0); chk("over_no_spawn", k);
    start = 1'b1;
    push(3); push(0); push(0);
    tick();
    start = 1'b0;
    chk("restart_lives", lives);
    chk("restart_score", score);
    chk("restart_over", game_over);

    // timeout with ready held high
    wait_spawn(n);
    traj_ready = 1'b1;
    k = 0;
    while (score !== 8'd1 && k < 250) begin
      tick();
      k++;
    end
    traj_ready = 1'b0;
    push(200); chk("timeout_clk", k);
    push(1); chk("timeout_score", score);

    // timeout in ARM: escape without score
    wait_spawn(n);
    repeat (200) tick();
    push(1); chk("arm_to_score", score);
    push(1); chk("arm_to_busy", busy);
    wait_spawn(n);
    push(9); chk("arm_to_gap", n);

    // saturate score at 255
    k = 0;
    while (score !== 8'd255 && k < 300) begin
      escape_one();
      k++;
    end
    push(255); chk("score_255", score);
    traj_ready = 1'b1;
    tick();
    traj_ready = 1'b0;
    tick();
    push(255); chk("score_sat", score);

    // reset mid-FLY is immediate
    wait_spawn(n);
    traj_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    push(0); chk("mid_rst_spawn", spawn);
    push(0); chk("mid_rst_angle", angle_state);
    push(0); chk("mid_rst_lives", lives);
    push(0); chk("mid_rst_score", score);
    push(0); chk("mid_rst_over", game_over);
    push(0); chk("mid_rst_busy", busy);
    traj_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    push(0); chk("post_rst_busy", busy);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_spawn(n);
    chk_angle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
